// File: rtl/dice_display_decoder.sv
// ============================================================================
//  Module      : dice_display_decoder
//  Description : Synchronises, debounces and decodes an active-low 7-segment
//                dice display back to a face value, with per-face histograms.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dice_display_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [6:0]       Dseg,
    input  logic             clr,
    input  logic [2:0]       rd_sel,
    output logic [2:0]       face,
    output logic             face_valid,
    output logic             invalid,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] total
);

    typedef enum logic [0:0] {
        SETTLING = 1'b0,
        HELD     = 1'b1
    } state_t;

    localparam logic [6:0]       c_BLANK    = 7'b1111111;
    localparam logic [7:0]       c_CNT_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_SAT      = '1;
    localparam logic [CNT_W-1:0] c_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [2:0] f_decode(input logic [6:0] pat);
        logic [2:0] n;
        case (pat)
            7'b1001111: n = 3'd1;
            7'b0010010: n = 3'd2;
            7'b0000110: n = 3'd3;
            7'b1001100: n = 3'd4;
            7'b0100100: n = 3'd5;
            7'b0100000: n = 3'd6;
            default:    n = 3'd0;
        endcase
        return n;
    endfunction

    logic [6:0]       r_s1;
    logic [6:0]       r_s2;
    logic [6:0]       r_cand;
    logic [6:0]       r_acc;
    logic [7:0]       r_cnt;
    state_t           r_state;
    logic [CNT_W-1:0] r_hist [1:6];

    logic             w_match;
    logic             w_settled;
    logic             w_commit;
    logic [2:0]       w_dec;
    logic             w_face_commit;
    logic             w_bad_commit;
    logic [CNT_W-1:0] w_rd_hist;

    // A settled candidate only produces an event if it differs from what was last accepted
    assign w_match       = (r_s2 == r_cand);
    assign w_settled     = (r_state == SETTLING) && w_match && (r_cnt == c_CNT_LAST);
    assign w_commit      = w_settled && (r_cand != r_acc);
    assign w_dec         = f_decode(r_cand);
    assign w_face_commit = w_commit && (w_dec != 3'd0);
    assign w_bad_commit  = w_commit && (w_dec == 3'd0) && (r_cand != c_BLANK);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_s1       <= c_BLANK;
            r_s2       <= c_BLANK;
            r_cand     <= c_BLANK;
            r_acc      <= c_BLANK;
            r_cnt      <= 8'd0;
            r_state    <= SETTLING;
            face       <= 3'd0;
            face_valid <= 1'b0;
            invalid    <= 1'b0;
        end else begin
            r_s1       <= Dseg;
            r_s2       <= r_s1;
            face_valid <= w_face_commit;
            invalid    <= w_bad_commit;
            if (w_face_commit) begin
                face <= w_dec;
            end
            case (r_state)
                SETTLING: begin
                    if (!w_match) begin
                        r_cand <= r_s2;
                        r_cnt  <= 8'd0;
                    end else if (r_cnt != c_CNT_LAST) begin
                        r_cnt <= r_cnt + 8'd1;
                    end else begin
                        r_state <= HELD;
                        if (w_commit) begin
                            r_acc <= r_cand;
                        end
                    end
                end
                HELD: begin
                    if (!w_match) begin
                        r_cand  <= r_s2;
                        r_cnt   <= 8'd0;
                        r_state <= SETTLING;
                    end
                end
                default: r_state <= SETTLING;
            endcase
        end
    end

    always_comb begin
        w_rd_hist = '0;
        for (int i = 1; i <= 6; i++) begin
            if (rd_sel == 3'(i)) begin
                w_rd_hist = r_hist[i];
            end
        end
    end

    // clr takes priority over a same-edge increment
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 1; i <= 6; i++) begin
                r_hist[i] <= '0;
            end
            total    <= '0;
            rd_count <= '0;
        end else begin
            rd_count <= w_rd_hist;
            if (clr) begin
                for (int i = 1; i <= 6; i++) begin
                    r_hist[i] <= '0;
                end
                total <= '0;
            end else if (w_face_commit) begin
                for (int i = 1; i <= 6; i++) begin
                    if ((w_dec == 3'(i)) && (r_hist[i] != c_SAT)) begin
                        r_hist[i] <= r_hist[i] + c_ONE;
                    end
                end
                if (total != c_SAT) begin
                    total <= total + c_ONE;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dice_display_decoder.sv
// ============================================================================
//  Module      : tb_dice_display_decoder
//  Description : Randomised bench for dice_display_decoder, two parameter sets.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dice_display_decoder;

    localparam int S0 = 4;
    localparam int W0 = 16;
    localparam int S1 = 2;
    localparam int W1 = 2;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic [6:0]    Dseg = 7'b1111111;
    logic          clr = 1'b0;
    logic [2:0]    rd_sel = 3'd0;

    logic [2:0]    face0, face1;
    logic          fv0, fv1, inv0, inv1;
    logic [W0-1:0] rdc0, tot0;
    logic [W1-1:0] rdc1, tot1;

    always #5 CLK = ~CLK;

    dice_display_decoder #(.STABLE_CYCLES(S0), .CNT_W(W0)) u_dut0 (
        .CLK(CLK), .nRST(nRST), .Dseg(Dseg), .clr(clr), .rd_sel(rd_sel),
        .face(face0), .face_valid(fv0), .invalid(inv0), .rd_count(rdc0), .total(tot0)
    );

    dice_display_decoder #(.STABLE_CYCLES(S1), .CNT_W(W1)) u_dut1 (
        .CLK(CLK), .nRST(nRST), .Dseg(Dseg), .clr(clr), .rd_sel(rd_sel),
        .face(face1), .face_valid(fv1), .invalid(inv1), .rd_count(rdc1), .total(tot1)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_fv0 = 0;
    int n_inv0 = 0;

    logic [6:0] pat [1:6];

    // Reference: a value is accepted once it has been seen on the synchronised
    // bus for STABLE_CYCLES+1 consecutive edges and differs from the last one.
    logic [6:0] m_p1, m_p2, m_run_val;
    int         m_run_len;
    logic [6:0] m_acc  [2];
    int         m_face [2];
    int         m_fv   [2];
    int         m_inv  [2];
    int         m_hist [2][1:6];
    int         m_tot  [2];
    int         m_rd   [2];
    int         m_stab [2];
    int         m_max  [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int face_of(input logic [6:0] p);
        for (int i = 1; i <= 6; i++) begin
            if (pat[i] == p) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_p1      = 7'b1111111;
        m_p2      = 7'b1111111;
        m_run_val = 7'b1111111;
        m_run_len = 1;
        for (int k = 0; k < 2; k++) begin
            m_acc[k]  = 7'b1111111;
            m_face[k] = 0;
            m_fv[k]   = 0;
            m_inv[k]  = 0;
            m_tot[k]  = 0;
            m_rd[k]   = 0;
            for (int i = 1; i <= 6; i++) m_hist[k][i] = 0;
        end
    endtask

    task automatic model_edge();
        logic [6:0] s2v;
        int n;
        s2v  = m_p2;
        m_p2 = m_p1;
        m_p1 = Dseg;
        if (s2v == m_run_val) m_run_len++;
        else begin
            m_run_val = s2v;
            m_run_len = 1;
        end
        for (int k = 0; k < 2; k++) begin
            m_rd[k]  = (rd_sel >= 3'd1 && rd_sel <= 3'd6) ? m_hist[k][int'(rd_sel)] : 0;
            m_fv[k]  = 0;
            m_inv[k] = 0;
            if (m_run_len == m_stab[k] + 1 && m_run_val != m_acc[k]) begin
                m_acc[k] = m_run_val;
                n = face_of(m_run_val);
                if (n != 0) begin
                    m_face[k] = n;
                    m_fv[k]   = 1;
                    if (m_hist[k][n] < m_max[k]) m_hist[k][n]++;
                    if (m_tot[k] < m_max[k]) m_tot[k]++;
                end else if (m_run_val != 7'b1111111) begin
                    m_inv[k] = 1;
                end
            end
            if (clr) begin
                m_tot[k] = 0;
                for (int i = 1; i <= 6; i++) m_hist[k][i] = 0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("face0",  32'(face0), 32'(m_face[0]));
        chk("fv0",    32'(fv0),   32'(m_fv[0]));
        chk("inv0",   32'(inv0),  32'(m_inv[0]));
        chk("total0", 32'(tot0),  32'(m_tot[0]));
        chk("rdcnt0", 32'(rdc0),  32'(m_rd[0]));
        chk("face1",  32'(face1), 32'(m_face[1]));
        chk("fv1",    32'(fv1),   32'(m_fv[1]));
        chk("inv1",   32'(inv1),  32'(m_inv[1]));
        chk("total1", 32'(tot1),  32'(m_tot[1]));
        chk("rdcnt1", 32'(rdc1),  32'(m_rd[1]));
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check_outputs();
        if (fv0)  n_fv0++;
        if (inv0) n_inv0++;
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        Dseg = p;
        repeat (n) step();
    endtask

    task automatic async_reset();
        #2 nRST = 1'b0;
        #1;
        model_reset();
        chk("rst_face0",  32'(face0), 32'd0);
        chk("rst_total0", 32'(tot0),  32'd0);
        chk("rst_fv0",    32'(fv0),   32'd0);
        check_outputs();
        #2 nRST = 1'b1;
    endtask

    initial begin
        logic [6:0] p;
        int r;
        pat = '{7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100, 7'b0100000};
        m_stab = '{S0, S1};
        m_max  = '{(1 << W0) - 1, (1 << W1) - 1};
        model_reset();
        #3;
        check_outputs();
        #9 nRST = 1'b1;

        // Blank bus after reset: nothing happens
        hold(7'b1111111, 20);
        chk("t1_face", 32'(face0), 32'd0);
        chk("t1_total", 32'(tot0), 32'd0);

        // First face: pulse registered on edge STABLE_CYCLES+3
        Dseg   = pat[2];
        rd_sel = 3'd2;
        repeat (6) step();
        chk("t2_early", 32'(fv0), 32'd0);
        step();
        chk("t2_pulse", 32'(fv0), 32'd1);
        chk("t2_face", 32'(face0), 32'd2);
        step();
        chk("t2_rd", 32'(rdc0), 32'd1);
        chk("t2_total", 32'(tot0), 32'd1);

        // Short glitch then return to accepted value
        hold(pat[4], 3);
        hold(pat[2], 10);
        chk("t3_face", 32'(face0), 32'd2);
        chk("t3_total", 32'(tot0), 32'd1);

        // All six faces in order
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_fv0 = 0;
        for (int f = 1; f <= 6; f++) hold(pat[f], 8);
        chk("t4_pulses", 32'(n_fv0), 32'd6);
        chk("t4_total", 32'(tot0), 32'd6);
        for (int f = 1; f <= 6; f++) begin
            rd_sel = 3'(f);
            step();
            chk("t4_hist", 32'(rdc0), 32'd1);
        end

        // Non-face pattern then face 6 again
        n_inv0 = 0;
        n_fv0  = 0;
        hold(7'b1111110, 8);
        chk("t5_inv", 32'(n_inv0), 32'd1);
        chk("t5_face", 32'(face0), 32'd6);
        chk("t5_total", 32'(tot0), 32'd6);
        hold(pat[6], 8);
        chk("t5_fv", 32'(n_fv0), 32'd1);

        // Saturation on the narrow instance
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 10; i++) hold((i % 2) ? pat[3] : pat[1], 6);
        rd_sel = 3'd1;
        step();
        chk("t6_hist1", 32'(rdc1), 32'd3);
        rd_sel = 3'd3;
        step();
        chk("t6_hist3", 32'(rdc1), 32'd3);
        chk("t6_total", 32'(tot1), 32'd3);

        // clr coinciding with a commit on the wide instance
        Dseg = pat[1];
        repeat (6) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t6_clr_fv", 32'(fv0), 32'd1);
        chk("t6_clr_tot", 32'(tot0), 32'd0);

        // Reset while settling
        Dseg = pat[5];
        repeat (2) step();
        async_reset();
        hold(pat[5], 10);

        // Randomised patterns, hold lengths, clears, read selects and resets
        p = pat[1];
        for (int seg = 0; seg < 300; seg++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 5)       p = pat[r + 1];
            else if (r == 6)  p = 7'b1111111;
            else if (r == 7)  p = 7'b0000000;
            else if (r == 8)  p = 7'($urandom);
            Dseg = p;
            for (int c = 0; c < int'($urandom_range(1, 9)); c++) begin
                rd_sel = 3'($urandom_range(0, 7));
                clr    = ($urandom_range(0, 29) == 0);
                step();
            end
            clr = 1'b0;
            if ($urandom_range(0, 39) == 0) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
